// File: rtl/eight_bit_reg_arbiter_pkg.sv
// Shared types and constants for the round-robin register arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_t;

  // Kept wide so any register width up to 64 can truncate from them.
  localparam logic [63:0] RESET_VAL  = '0;
  localparam logic [63:0] PRESET_VAL = '1;

endpackage

// File: rtl/eight_bit_reg_arbiter_if.sv
// Requester-side bus of the shared register: requests, data, grant handshake, readback.
interface eight_bit_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic                   ack;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       q_bar;

  modport master (output req, wdata, input gnt, ack, busy, q, q_bar);
  modport slave  (input req, wdata, output gnt, ack, busy, q, q_bar);
endinterface

// File: rtl/eight_bit_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    int j;
    logic [PTR_W-1:0] jj;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    jj     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jj = PTR_W'(j);
      if (!valid && req[jj]) begin
        valid      = 1'b1;
        onehot[jj] = 1'b1;
        idx        = jj;
      end
    end
  end

endmodule

// File: rtl/eight_bit_reg_arbiter.sv
// Shared register with round-robin write arbitration and grant/ack handshake.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no owner; pick a winner from pending requests
//   ST_WRITE | winner granted; load its data if req still held, else abort
//   ST_DONE  | ack pulse cycle; release grant and advance pointer
module eight_bit_reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     preset,
  eight_bit_reg_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [WIDTH-1:0] Q_RESET  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] Q_PRESET = WIDTH'(PRESET_VAL);

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [N_REQ-1:0] gnt_r;
  logic             ack_r;
  logic [WIDTH-1:0] q_r;

  logic [N_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic [WIDTH-1:0] wsel;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Select the latched winner's data slice with constant part-selects.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) wsel = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  // Register, grant handshake and round-robin pointer; preset overrides a write load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      win_idx <= '0;
      gnt_r   <= '0;
      ack_r   <= 1'b0;
      q_r     <= Q_RESET;
    end else begin
      if (preset) q_r <= Q_PRESET;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_r   <= pick_onehot;
            win_idx <= pick_idx;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus.req[win_idx]) begin
            if (!preset) q_r <= wsel;
            ack_r <= 1'b1;
            state <= ST_DONE;
          end else begin
            gnt_r <= '0;
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          gnt_r <= '0;
          ack_r <= 1'b0;
          ptr   <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.ack   = ack_r;
  assign bus.busy  = (state != ST_IDLE);
  assign bus.q     = q_r;
  assign bus.q_bar = ~q_r;

endmodule

// File: tb/tb_eight_bit_reg_arbiter.sv
// Directed bench for the round-robin register arbiter.
module tb_eight_bit_reg_arbiter;

  logic clk;
  logic rst;
  logic preset;
  int   checks;
  int   errors;

  eight_bit_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  eight_bit_reg_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .preset (preset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_q);
    check({tag, "_q"},     {24'd0, bus.q},     {24'd0, exp_q});
    check({tag, "_qbar"},  {24'd0, bus.q_bar}, {24'd0, ~exp_q});
    check({tag, "_gnt"},   {28'd0, bus.gnt},   32'd0);
    check({tag, "_ack"},   {31'd0, bus.ack},   32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy},  32'd0);
  endtask

  logic [7:0] rr_data [4];

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    preset = 1'b0;
    bus.req   = '0;
    bus.wdata = '0;
    rr_data[0] = 8'h11;
    rr_data[1] = 8'h22;
    rr_data[2] = 8'h33;
    rr_data[3] = 8'h44;

    // Reset, then idle for 5 cycles.
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check_idle_outputs("reset_idle", 8'h00);
    end

    // Single request on requester 2.
    bus.wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.req   = 4'b0100;
    step();
    check("single_e0_gnt",  {28'd0, bus.gnt},  32'h4);
    check("single_e0_busy", {31'd0, bus.busy}, 32'h1);
    check("single_e0_ack",  {31'd0, bus.ack},  32'h0);
    step();
    check("single_e1_q",    {24'd0, bus.q},    32'hA5);
    check("single_e1_ack",  {31'd0, bus.ack},  32'h1);
    check("single_e1_gnt",  {28'd0, bus.gnt},  32'h4);
    bus.req = '0;
    step();
    check_idle_outputs("single_e2", 8'hA5);

    // Reset to bring ptr back to 0, then all four requesters held.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_reset_q", {24'd0, bus.q}, 32'h00);
    bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr%0d_gnt", k), {28'd0, bus.gnt}, 32'(1 << (k % 4)));
      step();
      check($sformatf("rr%0d_q", k),   {24'd0, bus.q},   {24'd0, rr_data[k % 4]});
      check($sformatf("rr%0d_ack", k), {31'd0, bus.ack}, 32'h1);
      step();
      check($sformatf("rr%0d_rel_gnt", k), {28'd0, bus.gnt}, 32'h0);
      check($sformatf("rr%0d_rel_ack", k), {31'd0, bus.ack}, 32'h0);
    end
    bus.req = '0;
    step();
    check_idle_outputs("rr_end", 8'h11);

    // Abort: requester 1 drops req during WRITE; ptr stays at 1.
    bus.wdata = {8'h00, 8'h00, 8'h77, 8'h66};
    bus.req   = 4'b0010;
    step();
    check("abort_e0_gnt", {28'd0, bus.gnt}, 32'h2);
    bus.req = '0;
    step();
    check_idle_outputs("abort_e1", 8'h11);
    bus.req = 4'b0011;
    step();
    check("abort_regrant_gnt", {28'd0, bus.gnt}, 32'h2);
    step();
    check("abort_regrant_q",   {24'd0, bus.q},   32'h77);
    check("abort_regrant_ack", {31'd0, bus.ack}, 32'h1);
    bus.req = '0;
    step();
    check_idle_outputs("abort_done", 8'h77);

    // Preset coincident with the WRITE load; ptr now 2.
    bus.wdata = {8'h00, 8'h3C, 8'h00, 8'h00};
    bus.req   = 4'b0100;
    step();
    check("pw_e0_gnt", {28'd0, bus.gnt}, 32'h4);
    preset = 1'b1;
    step();
    preset = 1'b0;
    check("pw_e1_q",    {24'd0, bus.q},     32'hFF);
    check("pw_e1_qbar", {24'd0, bus.q_bar}, 32'h00);
    check("pw_e1_ack",  {31'd0, bus.ack},   32'h1);
    bus.req = '0;
    step();
    check_idle_outputs("pw_e2", 8'hFF);

    // Write 0x5A from requester 3 (ptr 3), then preset while idle.
    bus.wdata = {8'h5A, 8'h00, 8'h00, 8'h00};
    bus.req   = 4'b1000;
    step();
    check("pi_gnt", {28'd0, bus.gnt}, 32'h8);
    step();
    check("pi_q", {24'd0, bus.q}, 32'h5A);
    bus.req = '0;
    step();
    step();
    check_idle_outputs("pi_before", 8'h5A);
    preset = 1'b1;
    step();
    preset = 1'b0;
    check_idle_outputs("pi_after", 8'hFF);

    // Reset in DONE with ptr 0 and winner 2; next grant must be lowest active (1).
    bus.wdata = {8'hC3, 8'h81, 8'h5B, 8'h00};
    bus.req   = 4'b0100;
    step();
    check("rd_e0_gnt", {28'd0, bus.gnt}, 32'h4);
    step();
    check("rd_e1_q",   {24'd0, bus.q},   32'h81);
    check("rd_e1_ack", {31'd0, bus.ack}, 32'h1);
    rst     = 1'b1;
    bus.req = '0;
    step();
    rst = 1'b0;
    check_idle_outputs("rd_reset", 8'h00);
    bus.req = 4'b1010;
    step();
    check("rd_regrant_gnt", {28'd0, bus.gnt}, 32'h2);
    step();
    check("rd_regrant_q",   {24'd0, bus.q},   32'h5B);
    check("rd_regrant_ack", {31'd0, bus.ack}, 32'h1);
    bus.req = '0;
    step();
    check_idle_outputs("rd_end", 8'h5B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
